// File: rtl/serial_frame_rx.sv
// -----------------------------------------------------------------------------
// serial_frame_rx
//
// Serial-to-parallel frame receiver. A frame is a start bit (0), WIDTH data
// bits sent LSB first, an optional even-parity bit, and a stop bit (1). The
// receiver FSM advances only on cycles where BIT_EN is high, so any bit rate
// derived from CLK can be used. The output handshake runs every CLK cycle.
//
// Optional feature macro: SERIAL_FRAME_RX_PARITY_EN
//   defined   -> a PARITY state samples an even-parity bit after the data bits
//   undefined -> no parity bit in the frame, PARITY_ERR is constant 0
//
// Ports:
//   CLK         rising-edge clock
//   RESET       asynchronous, active-high reset
//   D_IN        serial data (idle level 1)
//   BIT_EN      bit-sample strobe; the FSM and shifter act only when high
//   DATA_ACK    downstream consumed DATA_OUT
//   DATA_OUT    last good received word
//   DATA_VALID  DATA_OUT holds an unconsumed word
//   FRAME_ERR   one-cycle pulse: stop bit sampled as 0
//   OVERRUN     sticky: a good frame was dropped while DATA_VALID was set
//   PARITY_ERR  one-cycle pulse: parity mismatch
//   BUSY        FSM is not in IDLE
//
// Handshake: DATA_VALID rises on the edge that samples a good stop bit and
// stays high until a cycle with DATA_ACK=1 while DATA_VALID=1; that edge
// clears it (and OVERRUN). If a good frame completes on that same edge, the
// new word is loaded and DATA_VALID stays high. DATA_ACK with DATA_VALID=0
// has no effect.
// -----------------------------------------------------------------------------
module serial_frame_rx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             D_IN,
    input  logic             BIT_EN,
    input  logic             DATA_ACK,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             DATA_VALID,
    output logic             FRAME_ERR,
    output logic             OVERRUN,
    output logic             PARITY_ERR,
    output logic             BUSY
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    localparam logic [1:0] S_PARITY = 2'd2;
`endif
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic             frame_err_q, frame_err_d;
    logic             overrun_q, overrun_d;
    logic             par_err_q, par_err_d;
    logic             stop_good;
    logic             par_bad;

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic par_bad_q, par_bad_d;
    assign par_bad = par_bad_q;
`else
    assign par_bad = 1'b0;
`endif

    // Receive FSM and shifter: only acts on BIT_EN cycles.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        frame_err_d = 1'b0;
        par_err_d   = 1'b0;
        stop_good   = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
        par_bad_d   = par_bad_q;
`endif
        if (BIT_EN) begin
            case (state_q)
                S_IDLE: begin
                    if (!D_IN) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                S_DATA: begin
                    // Right shift: after WIDTH bits the first (LSB) bit sits at bit 0.
                    shift_d = {D_IN, shift_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_BIT) begin
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
`ifdef SERIAL_FRAME_RX_PARITY_EN
                S_PARITY: begin
                    // Even parity: the parity bit equals the XOR of the data bits.
                    par_bad_d = D_IN ^ (^shift_q);
                    state_d   = S_STOP;
                end
`endif
                S_STOP: begin
                    state_d = S_IDLE;
                    if (!D_IN) begin
                        frame_err_d = 1'b1;
                    end else if (par_bad) begin
                        par_err_d = 1'b1;
                    end else begin
                        stop_good = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output handshake: evaluated every cycle.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        if (DATA_ACK && valid_q) begin
            valid_d   = 1'b0;
            overrun_d = 1'b0;
        end
        if (stop_good) begin
            if (!valid_q || DATA_ACK) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            par_err_q   <= 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_bad_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            par_err_q   <= par_err_d;
`ifdef SERIAL_FRAME_RX_PARITY_EN
            par_bad_q   <= par_bad_d;
`endif
        end
    end

    assign DATA_OUT   = data_q;
    assign DATA_VALID = valid_q;
    assign FRAME_ERR  = frame_err_q;
    assign OVERRUN    = overrun_q;
    assign PARITY_ERR = par_err_q;
    assign BUSY       = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_frame_rx.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_rx
//
// Directed bench for serial_frame_rx (WIDTH=8). The frame sequence runs twice:
// once with BIT_EN held high and once with BIT_EN high one cycle in four.
// Define SERIAL_FRAME_RX_PARITY_EN for both files to exercise the parity bit.
// -----------------------------------------------------------------------------
module tb_serial_frame_rx;

    logic       clk;
    logic       rst;
    logic       d_in;
    logic       bit_en;
    logic       data_ack;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;
    logic       busy;

    int n_checks;
    int n_fail;
    int bit_gap;

    serial_frame_rx #(.WIDTH(8), .CNT_W(4)) dut (
        .CLK       (clk),
        .RESET     (rst),
        .D_IN      (d_in),
        .BIT_EN    (bit_en),
        .DATA_ACK  (data_ack),
        .DATA_OUT  (data_out),
        .DATA_VALID(data_valid),
        .FRAME_ERR (frame_err),
        .OVERRUN   (overrun),
        .PARITY_ERR(parity_err),
        .BUSY      (busy)
    );

    // Clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge; outputs are sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one serial bit and strobe BIT_EN once, after bit_gap idle cycles.
    task automatic send_bit(input logic b);
        d_in = b;
        for (int g = 0; g < bit_gap; g++) begin
            bit_en = 1'b0;
            tick();
        end
        bit_en = 1'b1;
        tick();
        bit_en = 1'b0;
    endtask

    // Full frame; ack_on_stop asserts DATA_ACK on the stop-bit edge.
    // par_flip inverts the correct parity bit (no effect without parity).
    task automatic send_frame(input logic [7:0] data, input logic stop_bit,
                              input logic par_flip, input logic ack_on_stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
`ifdef SERIAL_FRAME_RX_PARITY_EN
        send_bit((^data) ^ par_flip);
`endif
        data_ack = ack_on_stop;
        send_bit(stop_bit);
        data_ack = 1'b0;
    endtask

    task automatic ack_cycle();
        d_in     = 1'b1;
        bit_en   = 1'b0;
        data_ack = 1'b1;
        tick();
        data_ack = 1'b0;
    endtask

    task automatic run_suite(input string p);
        // Reset with idle line and BIT_EN high
        rst = 1'b1; d_in = 1'b1; bit_en = 1'b1; data_ack = 1'b0;
        repeat (5) tick();
        check({p, " rst data_out"}, data_out, 8'h00);
        check({p, " rst valid"}, data_valid, 0);
        check({p, " rst frame_err"}, frame_err, 0);
        check({p, " rst overrun"}, overrun, 0);
        check({p, " rst parity_err"}, parity_err, 0);
        check({p, " rst busy"}, busy, 0);
        rst = 1'b0;
        tick();
        check({p, " idle busy"}, busy, 0);
        bit_en = 1'b0;

        // Good frame 0xA5, then ack
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check({p, " a5 data"}, data_out, 8'hA5);
        check({p, " a5 valid"}, data_valid, 1);
        check({p, " a5 busy"}, busy, 0);
        check({p, " a5 frame_err"}, frame_err, 0);
        ack_cycle();
        check({p, " a5 ack valid"}, data_valid, 0);
        check({p, " a5 ack data"}, data_out, 8'hA5);
        // Ack with nothing valid is ignored
        ack_cycle();
        check({p, " idle ack valid"}, data_valid, 0);

        // Bad stop bit on 0x3C
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        check({p, " 3c frame_err"}, frame_err, 1);
        check({p, " 3c valid"}, data_valid, 0);
        check({p, " 3c data"}, data_out, 8'hA5);
        bit_en = 1'b1; d_in = 1'b1;
        tick();
        check({p, " 3c frame_err pulse"}, frame_err, 0);
        tick();
        check({p, " 3c frame_err low"}, frame_err, 0);
        bit_en = 1'b0;

        // Overrun: 0xA5 then 0x5A with no ack
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check({p, " ovr first valid"}, data_valid, 1);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        check({p, " ovr data"}, data_out, 8'hA5);
        check({p, " ovr flag"}, overrun, 1);
        check({p, " ovr valid"}, data_valid, 1);
        ack_cycle();
        check({p, " ovr ack flag"}, overrun, 0);
        check({p, " ovr ack valid"}, data_valid, 0);

        // Reset in the middle of 0xFF, then 0x0F
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        check({p, " mid busy"}, busy, 1);
        rst = 1'b1;
        #2;
        check({p, " async rst busy"}, busy, 0);
        tick();
        rst = 1'b0;
        d_in = 1'b1;
        tick();
        check({p, " post rst data"}, data_out, 8'h00);
        check({p, " post rst valid"}, data_valid, 0);
        send_frame(8'h0F, 1'b1, 1'b0, 1'b0);
        check({p, " 0f data"}, data_out, 8'h0F);
        check({p, " 0f valid"}, data_valid, 1);
        check({p, " 0f frame_err"}, frame_err, 0);
        check({p, " 0f overrun"}, overrun, 0);
        check({p, " 0f parity_err"}, parity_err, 0);

        // Ack on the same edge a good frame completes: new word, still valid
        send_frame(8'h81, 1'b1, 1'b0, 1'b1);
        check({p, " ackstop data"}, data_out, 8'h81);
        check({p, " ackstop valid"}, data_valid, 1);
        check({p, " ackstop overrun"}, overrun, 0);
        ack_cycle();
        check({p, " ackstop clear"}, data_valid, 0);

`ifdef SERIAL_FRAME_RX_PARITY_EN
        // 0xA5 has four 1s: parity 0 is correct, 1 is a mismatch
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        check({p, " par ok valid"}, data_valid, 1);
        check({p, " par ok data"}, data_out, 8'hA5);
        check({p, " par ok err"}, parity_err, 0);
        ack_cycle();
        send_frame(8'hA5, 1'b1, 1'b1, 1'b0);
        check({p, " par bad err"}, parity_err, 1);
        check({p, " par bad valid"}, data_valid, 0);
        check({p, " par bad frame_err"}, frame_err, 0);
        bit_en = 1'b1; d_in = 1'b1;
        tick();
        check({p, " par bad pulse"}, parity_err, 0);
        bit_en = 1'b0;
        // 0x07 has three 1s: correct parity bit is 1
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        check({p, " par odd valid"}, data_valid, 1);
        check({p, " par odd data"}, data_out, 8'h07);
        ack_cycle();
`else
        send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
        check({p, " ff data"}, data_out, 8'hFF);
        check({p, " ff parity_err"}, parity_err, 0);
        ack_cycle();
`endif
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        d_in     = 1'b1;
        bit_en   = 1'b0;
        data_ack = 1'b0;

        bit_gap = 0;
        run_suite("en_full");
        bit_gap = 3;
        run_suite("en_1of4");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
